// File: rtl/kless_accl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : kless_accl_arbiter
//  Purpose  : Round-robin scheduler sharing one vector accelerator / SPM unit
//             between N_HARTS harts. One hart owns the accelerator at a time:
//             its command is captured, offered on a valid/ready handshake,
//             and the grant is held until the accelerator reports done or
//             the watchdog expires.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             req_i / cmd_i         - per-hart request level and command
//             grant_o               - one-hot owner while ISSUE/WAIT
//             accl_valid_o/_cmd_o/_hart_o, accl_ready_i, accl_done_i
//                                   - accelerator side handshake
//             done_o / err_o        - one-cycle completion / timeout pulses
//             busy_o                - arbiter not idle
//  Revision : 1.0 - initial release
// ============================================================================
module kless_accl_arbiter #(
  parameter int N_HARTS     = 3,
  parameter int CMD_W       = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_HARTS-1:0]                           req_i,
  input  logic [N_HARTS*CMD_W-1:0]                     cmd_i,
  output logic [N_HARTS-1:0]                           grant_o,
  output logic                                         accl_valid_o,
  output logic [CMD_W-1:0]                             accl_cmd_o,
  output logic [((N_HARTS > 1) ? $clog2(N_HARTS) : 1)-1:0] accl_hart_o,
  input  logic                                         accl_ready_i,
  input  logic                                         accl_done_i,
  output logic [N_HARTS-1:0]                           done_o,
  output logic [N_HARTS-1:0]                           err_o,
  output logic                                         busy_o
);

  localparam int HART_W    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
  localparam int WDOG_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [WDOG_W-1:0] TO_LAST   = TO_LAST_I[WDOG_W-1:0];
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
  localparam logic [HART_W-1:0] LAST_HART = HART_W'(N_HARTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [HART_W-1:0]    hart_q, hart_d;
  logic [HART_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_HARTS-1:0]   grant_q, grant_d;
  logic [N_HARTS-1:0]   done_q, done_d;
  logic [N_HARTS-1:0]   err_q, err_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;

  logic [HART_W-1:0]    pick;
  logic [CMD_W-1:0]     pick_cmd;
  logic [N_HARTS-1:0]   pick_onehot;
  logic [N_HARTS-1:0]   owner_onehot;
  logic                 timeout_hit;

  // First requesting hart, scanning from rr_ptr upward with wrap-around.
  function automatic logic [HART_W-1:0] rr_pick(input logic [N_HARTS-1:0] req,
                                                input logic [HART_W-1:0]  ptr);
    logic [HART_W-1:0] sel;
    logic              found;
    int                idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_HARTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_HARTS) idx = idx - N_HARTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx[HART_W-1:0];
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick         = rr_pick(req_i, rr_ptr_q);
    pick_cmd     = '0;
    pick_onehot  = '0;
    owner_onehot = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (pick == HART_W'(h)) begin
        pick_cmd       = cmd_i[h*CMD_W +: CMD_W];
        pick_onehot[h] = 1'b1;
      end
      if (hart_q == HART_W'(h)) owner_onehot[h] = 1'b1;
    end
  end

  // Watchdog fires on its last allowed WAIT cycle; disabled when TIMEOUT_CYC=0.
  assign timeout_hit = (TIMEOUT_CYC > 0) && (wdog_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    cmd_d    = cmd_q;
    hart_d   = hart_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    wdog_d   = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
          cmd_d   = pick_cmd;
          hart_d  = pick;
          grant_d = pick_onehot;
        end
      end
      S_ISSUE: begin
        // accl_done_i is meaningless before acceptance and is ignored here.
        if (accl_ready_i) begin
          state_d = S_WAIT;
          valid_d = 1'b0;
          wdog_d  = '0;
        end
      end
      S_WAIT: begin
        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
        if (accl_done_i || timeout_hit) begin
          // Done has priority over a simultaneous timeout.
          if (accl_done_i) done_d = owner_onehot;
          else             err_d  = owner_onehot;
          grant_d  = '0;
          state_d  = S_IDLE;
          rr_ptr_d = (hart_q == LAST_HART) ? '0 : hart_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      hart_q   <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      cmd_q    <= cmd_d;
      hart_q   <= hart_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign grant_o      = grant_q;
  assign accl_valid_o = valid_q;
  assign accl_cmd_o   = cmd_q;
  assign accl_hart_o  = hart_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kless_accl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kless_accl_arbiter
//  Purpose  : Directed self-checking bench for kless_accl_arbiter
//             (N_HARTS=3, CMD_W=64, TIMEOUT_CYC=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kless_accl_arbiter;

  localparam int N  = 3;
  localparam int CW = 64;
  localparam int TO = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_i;
  logic [N*CW-1:0] cmd_i;
  logic [N-1:0]    grant_o;
  logic            accl_valid_o;
  logic [CW-1:0]   accl_cmd_o;
  logic [1:0]      accl_hart_o;
  logic            accl_ready_i;
  logic            accl_done_i;
  logic [N-1:0]    done_o;
  logic [N-1:0]    err_o;
  logic            busy_o;

  int n_checks = 0;
  int n_errors = 0;

  kless_accl_arbiter #(
    .N_HARTS    (N),
    .CMD_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .cmd_i       (cmd_i),
    .grant_o     (grant_o),
    .accl_valid_o(accl_valid_o),
    .accl_cmd_o  (accl_cmd_o),
    .accl_hart_o (accl_hart_o),
    .accl_ready_i(accl_ready_i),
    .accl_done_i (accl_done_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 64'(grant_o), 64'h0);
    check({tag, "_valid"}, 64'(accl_valid_o), 64'h0);
    check({tag, "_busy"},  64'(busy_o), 64'h0);
    check({tag, "_done"},  64'(done_o), 64'h0);
    check({tag, "_err"},   64'(err_o), 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One round-robin service with ready and done returned back to back.
  task automatic serve(input logic [1:0] exp_hart, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_hart] = 1'b1;
    tick();
    check({tag, "_hart"},  64'(accl_hart_o), 64'(exp_hart));
    check({tag, "_grant"}, 64'(grant_o), 64'(oh));
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    accl_done_i  = 1'b1;
    tick();
    accl_done_i  = 1'b0;
    check({tag, "_done"}, 64'(done_o), 64'(oh));
  endtask

  initial begin
    rst_n        = 1'b0;
    req_i        = '0;
    cmd_i        = '0;
    accl_ready_i = 1'b0;
    accl_done_i  = 1'b0;
    cmd_i[0*CW +: CW] = 64'hA0A0_0000_0000_0A0A;
    cmd_i[1*CW +: CW] = 64'hB1B1_1111_2222_3333;
    cmd_i[2*CW +: CW] = 64'hC2C2_4444_5555_6666;

    // ---- Reset state ----
    tick();
    tick();
    check_idle_outputs("rst");
    check("rst_cmd",  64'(accl_cmd_o), 64'h0);
    check("rst_hart", 64'(accl_hart_o), 64'h0);
    rst_n = 1'b1;
    tick();

    // ---- 1: single request from hart 1 ----
    req_i = 3'b010;
    tick();
    check("t1_valid0", 64'(accl_valid_o), 64'h1);
    check("t1_hart",   64'(accl_hart_o), 64'h1);
    check("t1_grant",  64'(grant_o), 64'h2);
    check("t1_cmd",    accl_cmd_o, 64'hB1B1_1111_2222_3333);
    check("t1_busy",   64'(busy_o), 64'h1);
    tick();
    check("t1_valid1", 64'(accl_valid_o), 64'h1);
    tick();
    check("t1_valid2", 64'(accl_valid_o), 64'h1);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    check("t1_valid3", 64'(accl_valid_o), 64'h0);
    check("t1_grant_wait", 64'(grant_o), 64'h2);
    for (int i = 0; i < 4; i++) tick();
    check("t1_nodone_early", 64'(done_o), 64'h0);
    accl_done_i = 1'b1;
    tick();
    accl_done_i = 1'b0;
    req_i = '0;
    check("t1_done",       64'(done_o), 64'h2);
    check("t1_grant_pls",  64'(grant_o), 64'h0);
    check("t1_busy_after", 64'(busy_o), 64'h0);
    check("t1_err",        64'(err_o), 64'h0);
    tick();
    check("t1_done_1cyc",  64'(done_o), 64'h0);

    // ---- 2: round robin with all harts requesting ----
    do_reset();
    req_i = 3'b111;
    serve(2'd0, "t2_a");
    serve(2'd1, "t2_b");
    serve(2'd2, "t2_c");
    serve(2'd0, "t2_d");
    req_i = '0;
    tick();
    check_idle_outputs("t2_end");

    // ---- 3: timeout on hart 2 (rr_ptr now 1) ----
    req_i = 3'b100;
    tick();
    check("t3_hart", 64'(accl_hart_o), 64'h2);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    check("t3_err_early", 64'(err_o), 64'h0);
    check("t3_busy_wait", 64'(busy_o), 64'h1);
    tick();
    req_i = '0;
    check("t3_err",   64'(err_o), 64'h4);
    check("t3_done",  64'(done_o), 64'h0);
    check("t3_grant", 64'(grant_o), 64'h0);
    check("t3_busy",  64'(busy_o), 64'h0);
    tick();
    check("t3_err_1cyc", 64'(err_o), 64'h0);

    // ---- 4a/4c: done in ISSUE ignored, req dropped in ISSUE (rr_ptr 0) ----
    req_i = 3'b001;
    tick();
    check("t4a_hart", 64'(accl_hart_o), 64'h0);
    req_i = '0;
    accl_done_i = 1'b1;
    tick();
    check("t4a_valid_hold", 64'(accl_valid_o), 64'h1);
    check("t4a_done_ign",   64'(done_o), 64'h0);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    accl_done_i  = 1'b0;
    check("t4a_done_ign_rdy", 64'(done_o), 64'h0);
    check("t4a_busy",         64'(busy_o), 64'h1);
    check("t4a_grant",        64'(grant_o), 64'h1);
    tick();
    accl_done_i = 1'b1;
    tick();
    accl_done_i = 1'b0;
    check("t4c_done", 64'(done_o), 64'h1);
    tick();

    // ---- 4b: done exactly when wdog==7 (rr_ptr 1) ----
    req_i = 3'b010;
    tick();
    check("t4b_hart", 64'(accl_hart_o), 64'h1);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    req_i = '0;
    for (int i = 0; i < TO - 1; i++) tick();
    accl_done_i = 1'b1;
    tick();
    accl_done_i = 1'b0;
    check("t4b_done", 64'(done_o), 64'h2);
    check("t4b_err",  64'(err_o), 64'h0);
    tick();
    check("t4b_err_after", 64'(err_o), 64'h0);

    // ---- 6: command capture (rr_ptr 2) ----
    req_i = 3'b010;
    tick();
    check("t6_hart", 64'(accl_hart_o), 64'h1);
    cmd_i[1*CW +: CW] = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    check("t6_cmd_issue", accl_cmd_o, 64'hB1B1_1111_2222_3333);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    req_i = '0;
    check("t6_cmd_wait", accl_cmd_o, 64'hB1B1_1111_2222_3333);
    accl_done_i = 1'b1;
    tick();
    accl_done_i = 1'b0;
    check("t6_done", 64'(done_o), 64'h2);
    tick();

    // ---- 5: asynchronous reset in WAIT (rr_ptr 2, hart 0 requested) ----
    req_i = 3'b001;
    tick();
    check("t5_hart", 64'(accl_hart_o), 64'h0);
    accl_ready_i = 1'b1;
    tick();
    accl_ready_i = 1'b0;
    req_i = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    check("t5_cmd", 64'(accl_cmd_o), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    req_i = 3'b111;
    tick();
    check("t5_rr_reset", 64'(accl_hart_o), 64'h0);
    check("t5_grant",    64'(grant_o), 64'h1);
    req_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
